cache_ctrl_2way: RTL
====================

Name: cache_ctrl_2way

Overview:
- Two-way set-associative, write-through, no-write-allocate data cache controller between the MEM stage and the SRAM controller.
- Serves MEM-stage loads and stores from a 64-bit-block cache.
- Sequences SRAM reads on a miss and SRAM writes on every store.
- Drives `ready`, whose inverse is the pipeline freeze that holds the IF/ID/EX/MEM stage registers and the MEM/WB register.

Parameters:
- INDEX_W, 6, set index width (SETS = 2**INDEX_W = 64).
- TAG_W, 10, tag width; address split is tag = addr[18:9], index = addr[8:3], word select = addr[2]; addr[1:0] ignored.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- rd_en  input  1  MEM-stage load request
- wr_en  input  1  MEM-stage store request
- addr  input  32  byte address; held stable while ready=0
- wdata  input  32  store data; held stable while ready=0
- rdata  output  32  load data; valid when rd_en && ready
- ready  output  1  request complete this cycle / no request; freeze = ~ready
- sram_rd_en  output  1  block read request to SRAM controller
- sram_wr_en  output  1  word write request to SRAM controller
- sram_addr  output  32  SRAM address
- sram_wdata  output  32  SRAM write data
- sram_rdata  input  64  returned block; {word1, word0}
- sram_ready  input  1  SRAM controller completion strobe, one cycle

Behaviour:
- Storage per set, per way: valid bit, TAG_W tag, 64-bit data. Per set: one LRU bit (lru = way most recently used).
- Reset (async):
  - all valid bits = 0, all LRU bits = 0, state = IDLE.
  - sram_rd_en = 0, sram_wr_en = 0, sram_addr = 0, sram_wdata = 0.
  - rdata = 0; ready = 1 when no request is present.
- Reset mid-transaction: SRAM enables drop immediately and the pending request is abandoned. The SRAM controller is reset by the same rst.
- Hit: way w hits if valid[w] and tag[w] == addr tag. Both ways can never hit simultaneously.
- rd_en and wr_en both high: wr_en has priority; the load is ignored.
- States: IDLE, RD_MISS, WRITE.
- IDLE:
  - No request: ready = 1, rdata = 0, no SRAM activity.
  - Read hit: rdata = selected word of hit way, combinationally; ready = 1 in the same cycle (zero stall). LRU[index] = hit way at the clock edge.
  - Read miss: ready = 0; next state RD_MISS.
  - Write (hit or miss): ready = 0; next state WRITE.
- RD_MISS:
  - sram_rd_en = 1, sram_addr = {addr[31:3], 3'b000}, held until sram_ready.
  - In the sram_ready cycle:
    - rdata = sram_rdata word selected by addr[2]; ready = 1.
    - At the edge, victim way = first invalid way (way0 before way1); if both ways are valid, victim = ~LRU[index].
    - Victim gets valid = 1, tag, data = sram_rdata; LRU[index] = victim.
    - Next state IDLE; sram_rd_en deasserts the following cycle.
- WRITE:
  - sram_wr_en = 1, sram_addr = addr, sram_wdata = wdata, held until sram_ready.
  - In the sram_ready cycle: ready = 1.
  - If hit: at the edge, the addressed word of the hit way = wdata and LRU[index] = hit way.
  - If miss: no allocation, no LRU change.
  - Next state IDLE.
- Latency:
  - Read hit: 0 stall cycles.
  - Read miss: 1 + N cycles, where N is the SRAM controller latency.
  - Write: 1 + N cycles.
- ready is 1 in exactly one cycle per request (the completion cycle). Since addr is held while frozen, a request is never re-issued.
- sram_rd_en and sram_wr_en are never high together.
- If sram_ready is asserted while in IDLE, it is ignored.

Test Plan:
- Idle: rd_en = wr_en = 0 for 5 cycles -> ready = 1 throughout; sram_rd_en = sram_wr_en = 0.
- Cold read miss, then hit:
  - Stimulus: read 0x0000_0404; SRAM returns 64'h2222_2222_1111_1111 after 3 cycles.
  - Required: sram_rd_en high with sram_addr 0x400 until sram_ready; ready = 0 before that; rdata = 0x2222_2222 with ready = 1 in the sram_ready cycle.
  - Then read 0x400 -> hit in the same cycle, rdata = 0x1111_1111, no SRAM request.
- LRU replacement:
  - Stimulus: fill 0x400 (tag 2) and 0x600 (tag 3) in set 0; read 0x400 (hit); read 0x800 (miss).
  - Required: 0x800 evicts the 0x600 way. Subsequent read 0x400 hits; read 0x600 misses.
- Write hit, then write miss:
  - Stimulus: with 0x400 cached, write 0x404 = 0xDEAD_BEEF.
  - Required: sram_wr_en with sram_addr 0x404, sram_wdata 0xDEAD_BEEF; ready only in the sram_ready cycle; subsequent read 0x404 hits with 0xDEAD_BEEF.
  - Then write 0xA00 (miss) -> SRAM write only; subsequent read 0xA00 misses.
- Simultaneous rd_en = wr_en = 1 at 0x400 -> WRITE path taken; no sram_rd_en.
- Reset mid-miss:
  - Stimulus: assert rst while in RD_MISS.
  - Required: sram_rd_en = 0 immediately; after release, read 0x400 misses (all valid bits cleared).

Source files
------------

// File: rtl/cache_ctrl_2way.sv
// Two-way set-associative write-through data cache controller.
// Sits between the MEM stage and the SRAM controller; ready low freezes the pipe.
module cache_ctrl_2way #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);

    localparam int SETS = 2 ** INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        RD_MISS,
        WRITE
    } state_t;

    state_t state;
    state_t state_next;

    logic [SETS-1:0]  valid0;
    logic [SETS-1:0]  valid1;
    logic [SETS-1:0]  lru;
    logic [TAG_W-1:0] tag0  [SETS];
    logic [TAG_W-1:0] tag1  [SETS];
    logic [63:0]      data0 [SETS];
    logic [63:0]      data1 [SETS];

    logic [TAG_W-1:0]   a_tag;
    logic [INDEX_W-1:0] a_idx;
    logic               word_sel;
    logic               hit0;
    logic               hit1;
    logic               hit;
    logic [63:0]        hit_blk;
    logic               victim;
    logic               fill;
    logic               wr_upd;
    logic               touch;

    assign a_tag    = addr[3+INDEX_W +: TAG_W];
    assign a_idx    = addr[3 +: INDEX_W];
    assign word_sel = addr[2];
    assign hit0     = valid0[a_idx] && (tag0[a_idx] == a_tag);
    assign hit1     = valid1[a_idx] && (tag1[a_idx] == a_tag);
    assign hit      = hit0 | hit1;
    assign hit_blk  = hit1 ? data1[a_idx] : data0[a_idx];
    // First invalid way wins; with both valid, replace the least recently used.
    assign victim   = !valid0[a_idx] ? 1'b0 :
                      !valid1[a_idx] ? 1'b1 : ~lru[a_idx];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state, handshake outputs and SRAM request drive.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        rdata      = '0;
        sram_rd_en = 1'b0;
        sram_wr_en = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        fill       = 1'b0;
        wr_upd     = 1'b0;
        touch      = 1'b0;
        unique case (state)
            IDLE: begin
                if (wr_en) begin
                    state_next = WRITE;
                end else if (rd_en) begin
                    if (hit) begin
                        ready = 1'b1;
                        rdata = word_sel ? hit_blk[63:32] : hit_blk[31:0];
                        touch = 1'b1;
                    end else begin
                        state_next = RD_MISS;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            RD_MISS: begin
                sram_rd_en = 1'b1;
                sram_addr  = {addr[31:3], 3'b000};
                if (sram_ready) begin
                    ready      = 1'b1;
                    rdata      = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
                    fill       = 1'b1;
                    state_next = IDLE;
                end
            end
            WRITE: begin
                sram_wr_en = 1'b1;
                sram_addr  = addr;
                sram_wdata = wdata;
                if (sram_ready) begin
                    ready      = 1'b1;
                    wr_upd     = hit;
                    touch      = hit;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Valid and LRU bits; cleared on reset so the cache starts cold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid0 <= '0;
            valid1 <= '0;
            lru    <= '0;
        end else if (fill) begin
            if (victim) valid1[a_idx] <= 1'b1;
            else        valid0[a_idx] <= 1'b1;
            lru[a_idx] <= victim;
        end else if (touch) begin
            lru[a_idx] <= hit1;
        end
    end

    // Tag and data arrays: block fill on miss, word update on store hit.
    always_ff @(posedge clk) begin
        if (fill) begin
            if (victim) begin
                tag1[a_idx]  <= a_tag;
                data1[a_idx] <= sram_rdata;
            end else begin
                tag0[a_idx]  <= a_tag;
                data0[a_idx] <= sram_rdata;
            end
        end else if (wr_upd) begin
            if (hit1) begin
                if (word_sel) data1[a_idx][63:32] <= wdata;
                else          data1[a_idx][31:0]  <= wdata;
            end else begin
                if (word_sel) data0[a_idx][63:32] <= wdata;
                else          data0[a_idx][31:0]  <= wdata;
            end
        end
    end

endmodule
